// File: rtl/iic_slave.sv
// Single-address I2C target: START/STOP detect, address match, byte write and read.
// SCL is only observed; SDA is pulled low or released, never driven high.
module iic_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rd_req,
    output logic       busy,
    inout  wire        sda,
    inout  wire        scl
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE_BYTE,
        WRITE_ACK,
        READ_BYTE,
        READ_ACK,
        READ_LOAD,
        IGNORE
    } state_t;

    state_t     state;
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_prev;
    logic       sda_prev;
    logic [7:0] shreg;
    logic [2:0] cnt;
    logic       rw;
    logic       phase;
    logic       sda_oe;

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign sda = sda_oe ? 1'b0 : 1'bz;

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & sda_prev & ~sda_s;
    assign stop_det  = scl_s & ~sda_prev & sda_s;

    // Bus idles high, so the synchronizers reset to 1 to avoid false edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_prev <= scl_sync[1];
            sda_prev <= sda_sync[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= 8'h00;
            cnt      <= 3'd7;
            rw       <= 1'b0;
            phase    <= 1'b0;
            sda_oe   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            rd_req   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rd_req   <= 1'b0;
            if (start_det) begin
                state  <= ADDR;
                cnt    <= 3'd7;
                phase  <= 1'b0;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shreg <= {shreg[6:0], sda_s};
                            if (cnt == 3'd0) begin
                                cnt <= 3'd7;
                                if (shreg[6:0] == SLAVE_ADDR) begin
                                    rw     <= sda_s;
                                    busy   <= 1'b1;
                                    rd_req <= sda_s;
                                    phase  <= 1'b0;
                                    state  <= ADDR_ACK;
                                end else begin
                                    state <= IGNORE;
                                end
                            end else begin
                                cnt <= cnt - 3'd1;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!phase) begin
                                sda_oe <= 1'b1;
                                phase  <= 1'b1;
                            end else if (!rw) begin
                                sda_oe <= 1'b0;
                                cnt    <= 3'd7;
                                state  <= WRITE_BYTE;
                            end else begin
                                shreg  <= tx_data;
                                sda_oe <= ~tx_data[7];
                                cnt    <= 3'd7;
                                phase  <= 1'b0;
                                state  <= READ_BYTE;
                            end
                        end
                    end
                    WRITE_BYTE: begin
                        if (scl_rise) begin
                            shreg <= {shreg[6:0], sda_s};
                            if (cnt == 3'd0) begin
                                rx_data  <= {shreg[6:0], sda_s};
                                rx_valid <= 1'b1;
                                cnt      <= 3'd7;
                                phase    <= 1'b0;
                                state    <= WRITE_ACK;
                            end else begin
                                cnt <= cnt - 3'd1;
                            end
                        end
                    end
                    WRITE_ACK: begin
                        if (scl_fall) begin
                            if (!phase) begin
                                sda_oe <= 1'b1;
                                phase  <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                                cnt    <= 3'd7;
                                state  <= WRITE_BYTE;
                            end
                        end
                    end
                    READ_BYTE: begin
                        // phase marks that bit 0 has been clocked out
                        if (scl_rise) begin
                            if (cnt == 3'd0) begin
                                phase <= 1'b1;
                            end else begin
                                cnt <= cnt - 3'd1;
                            end
                        end else if (scl_fall) begin
                            if (phase) begin
                                sda_oe <= 1'b0;
                                state  <= READ_ACK;
                            end else begin
                                sda_oe <= ~shreg[6];
                                shreg  <= {shreg[6:0], 1'b0};
                            end
                        end
                    end
                    READ_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s) begin
                                rd_req <= 1'b1;
                                state  <= READ_LOAD;
                            end else begin
                                busy   <= 1'b0;
                                sda_oe <= 1'b0;
                                state  <= IGNORE;
                            end
                        end
                    end
                    READ_LOAD: begin
                        if (scl_fall) begin
                            shreg  <= tx_data;
                            sda_oe <= ~tx_data[7];
                            cnt    <= 3'd7;
                            phase  <= 1'b0;
                            state  <= READ_BYTE;
                        end
                    end
                    IGNORE: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iic_slave.sv
// Directed bench for iic_slave: a bit-banged I2C master on pulled-up
// open-drain lines, with immediate assertions at each check point.
module tb_iic_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    wire  [7:0] rx_data;
    wire        rx_valid;
    wire        rd_req;
    wire        busy;
    wire        sda;
    wire        scl;

    logic m_sda_rel = 1'b1;
    logic m_scl_rel = 1'b1;

    int checks = 0;
    int errors = 0;

    int         rxv_cnt = 0;
    int         rdq_cnt = 0;
    logic [7:0] rx_last = 8'h00;
    logic       slave_pull = 1'b0;
    logic       busy_seen = 1'b0;

    logic       ack;
    logic [7:0] rd;

    pullup (sda);
    pullup (scl);
    assign sda = m_sda_rel ? 1'bz : 1'b0;
    assign scl = m_scl_rel ? 1'bz : 1'b0;

    iic_slave dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rd_req   (rd_req),
        .busy     (busy),
        .sda      (sda),
        .scl      (scl)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt++;
            rx_last = rx_data;
        end
        if (rd_req) rdq_cnt++;
        if (m_sda_rel && sda === 1'b0) slave_pull = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic start_c();
        m_sda_rel = 1'b1;
        half();
        m_scl_rel = 1'b1;
        half();
        m_sda_rel = 1'b0;
        half();
        m_scl_rel = 1'b0;
        half();
    endtask

    task automatic stop_c();
        m_sda_rel = 1'b0;
        half();
        m_scl_rel = 1'b1;
        half();
        m_sda_rel = 1'b1;
        half();
    endtask

    task automatic wr_bit(input logic b);
        m_sda_rel = b;
        half();
        m_scl_rel = 1'b1;
        half();
        m_scl_rel = 1'b0;
        half();
    endtask

    task automatic rd_bit(output logic b);
        m_sda_rel = 1'b1;
        half();
        m_scl_rel = 1'b1;
        repeat (4) @(negedge clk);
        b = sda;
        repeat (4) @(negedge clk);
        m_scl_rel = 1'b0;
        half();
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic a);
        for (int i = 7; i >= 0; i--) wr_bit(d[i]);
        rd_bit(a);
    endtask

    task automatic rd_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rd_bit(b);
            d[i] = b;
        end
        wr_bit(nack);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rd_req", rd_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sda", sda, 1'b1);
        rst = 1'b0;
        half();

        // single-byte write
        start_c();
        wr_byte(8'h84, ack);
        check("w_addr_ack", ack, 1'b0);
        check("w_busy", busy, 1'b1);
        wr_byte(8'hA5, ack);
        check("w_data_ack", ack, 1'b0);
        stop_c();
        half();
        check("w_rxv_cnt", rxv_cnt, 1);
        check("w_rx_last", rx_last, 8'hA5);
        check("w_rx_data", rx_data, 8'hA5);
        check("w_busy_end", busy, 1'b0);

        // single-byte read, master NACK
        tx_data = 8'h3C;
        start_c();
        wr_byte(8'h85, ack);
        check("r_addr_ack", ack, 1'b0);
        check("r_rd_req", rdq_cnt, 1);
        rd_byte(rd, 1'b1);
        check("r_data", rd, 8'h3C);
        check("r_sda_rel", sda, 1'b1);
        check("r_busy_nack", busy, 1'b0);
        check("r_rd_req_nack", rdq_cnt, 1);
        stop_c();

        // address mismatch
        slave_pull = 1'b0;
        busy_seen  = 1'b0;
        start_c();
        wr_byte(8'h2E, ack);
        check("m_addr_nack", ack, 1'b1);
        wr_byte(8'h99, ack);
        check("m_data_nack", ack, 1'b1);
        stop_c();
        check("m_no_pull", slave_pull, 1'b0);
        check("m_no_busy", busy_seen, 1'b0);
        check("m_rxv_cnt", rxv_cnt, 1);

        // multi-byte write
        start_c();
        wr_byte(8'h84, ack);
        check("mb_addr_ack", ack, 1'b0);
        wr_byte(8'h01, ack);
        check("mb_ack0", ack, 1'b0);
        check("mb_rx0", rx_last, 8'h01);
        wr_byte(8'h02, ack);
        check("mb_ack1", ack, 1'b0);
        check("mb_rx1", rx_last, 8'h02);
        wr_byte(8'hFF, ack);
        check("mb_ack2", ack, 1'b0);
        check("mb_rx2", rx_last, 8'hFF);
        stop_c();
        check("mb_rxv_cnt", rxv_cnt, 4);

        // repeated START: write then read
        tx_data = 8'h81;
        start_c();
        wr_byte(8'h84, ack);
        check("rs_waddr_ack", ack, 1'b0);
        wr_byte(8'h10, ack);
        check("rs_wdata_ack", ack, 1'b0);
        check("rs_rx", rx_last, 8'h10);
        start_c();
        wr_byte(8'h85, ack);
        check("rs_raddr_ack", ack, 1'b0);
        check("rs_rd_req", rdq_cnt, 2);
        rd_byte(rd, 1'b1);
        check("rs_rdata", rd, 8'h81);
        stop_c();
        check("rs_busy_end", busy, 1'b0);
        check("rs_rxv_cnt", rxv_cnt, 5);

        // reset while the slave pulls SDA low in READ_BYTE
        tx_data = 8'h00;
        start_c();
        wr_byte(8'h85, ack);
        check("mr_addr_ack", ack, 1'b0);
        check("mr_sda_driven", sda, 1'b0);
        rst = 1'b1;
        #1;
        check("mr_sda_rel", sda, 1'b1);
        check("mr_busy", busy, 1'b0);
        check("mr_rx_valid", rx_valid, 1'b0);
        check("mr_rd_req", rd_req, 1'b0);
        check("mr_rx_data", rx_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        half();
        stop_c();
        start_c();
        wr_byte(8'h84, ack);
        check("mr_w_addr_ack", ack, 1'b0);
        wr_byte(8'h6E, ack);
        check("mr_w_data_ack", ack, 1'b0);
        stop_c();
        half();
        check("mr_rx_data_new", rx_data, 8'h6E);
        check("mr_rxv_cnt", rxv_cnt, 6);
        check("mr_busy_end", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
